// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcode values, the
// sequencer FSM state encoding and the default error byte sent when a
// divide by zero is trapped.
package alu_cmd_sequencer_pkg;

    // Opcodes as presented on cmd_op and forwarded on ALU_FUN_LS.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Sequencer state encoding.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_SEND_LO = 3'd3;
    localparam logic [2:0] ST_SEND_HI = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_ISSUE   = ST_ISSUE,
        S_WAIT    = ST_WAIT,
        S_SEND_LO = ST_SEND_LO,
        S_SEND_HI = ST_SEND_HI,
        S_ERR     = ST_ERR
    } state_e;

    // Byte returned in place of a result for a trapped divide by zero.
    localparam logic [7:0] ERR_CODE_DEFAULT = 8'hEE;

endpackage

// File: rtl/alu_result_serializer.sv
// Result register and UART TX byte handshake for the ALU command sequencer.
// Captures the arithmetic unit's 2*DATA_WIDTH result when told to, then
// presents the low byte, the high byte or the error code according to which
// send strobe the controlling FSM asserts.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   capture         load {res_hi, res_lo} into the result register
//   res_lo, res_hi  result halves from the arithmetic unit
//   send_lo/hi/err  which byte the FSM currently wants on the TX path
//   tx_ready        UART TX accepts the byte
//   tx_data         byte to UART TX
//   tx_valid        tx_data valid
//   tx_fire         a byte transfers on the coming edge
module alu_result_serializer #(
    parameter int         DATA_WIDTH = 8,
    parameter logic [7:0] ERR_CODE   = 8'hEE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] res_lo,
    input  logic [DATA_WIDTH-1:0] res_hi,
    input  logic                  send_lo,
    input  logic                  send_hi,
    input  logic                  send_err,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  tx_fire
);

    logic [2*DATA_WIDTH-1:0] result_q, result_d;

    always_comb begin
        result_d = capture ? {res_hi, res_lo} : result_q;
    end

    // NOTE: the result register is a plain flop with a reset value, not a
    // memory, so it is cleared with the rest of the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    // Byte selection is decoded from the FSM state, so tx_data holds for as
    // long as the FSM waits in a send state, and tx_valid falls the moment
    // the FSM is reset.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        if (send_lo) begin
            tx_valid = 1'b1;
            tx_data  = result_q[7:0];
        end else if (send_hi) begin
            tx_valid = 1'b1;
            tx_data  = result_q[15:8];
        end else if (send_err) begin
            tx_valid = 1'b1;
            tx_data  = ERR_CODE;
        end
    end

    assign tx_fire = tx_valid && tx_ready;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer that owns the arithmetic unit. Accepts one command at a
// time, drives the unit for exactly one cycle, captures its registered
// result and streams it to UART TX low byte first. Divide by zero is trapped
// before issue and answered with a single error byte.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_op, cmd_a, cmd_b         opcode and operands
//   A_Arith, B_Arith, ALU_FUN_LS operands/function to the arithmetic unit
//   Arith_En                     arithmetic unit enable (ISSUE only)
//   Arith_OUT_reg/Carry_OUT_reg  result low/high halves from the unit
//   Arith_Flag_reg               result-valid flag from the unit (unused)
//   tx_data/tx_valid/tx_ready    byte stream to UART TX
//   div0_err                     one-cycle pulse on a trapped divide by zero
//   op_cnt                       completed command count, wraps at 0xFF
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter logic [7:0] ERR_CODE   = ERR_CODE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic [DATA_WIDTH-1:0] A_Arith,
    output logic [DATA_WIDTH-1:0] B_Arith,
    output logic [1:0]            ALU_FUN_LS,
    output logic                  Arith_En,
    input  logic [DATA_WIDTH-1:0] Arith_OUT_reg,
    input  logic [DATA_WIDTH-1:0] Carry_OUT_reg,
    input  logic                  Arith_Flag_reg,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  div0_err,
    output logic [7:0]            op_cnt
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [1:0]            fun_q, fun_d;
    logic [7:0]            op_cnt_q, op_cnt_d;
    logic                  div0_err_q, div0_err_d;
    logic                  tx_fire;

    // The result is taken in WAIT regardless of the flag; the flag is
    // deliberately left out of the control path.
    logic flag_unused;
    assign flag_unused = Arith_Flag_reg;

    // NOTE: every variable gets its default first so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        fun_d      = fun_q;
        op_cnt_d   = op_cnt_q;
        div0_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    a_d   = cmd_a;
                    b_d   = cmd_b;
                    fun_d = cmd_op;
                    // Trap before issue so the unit never sees a zero divisor.
                    if (cmd_op == OP_DIV && cmd_b == '0) begin
                        state_d    = S_ERR;
                        div0_err_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    state_d = S_SEND_LO;
            S_SEND_LO: if (tx_fire) state_d = S_SEND_HI;
            S_SEND_HI, S_ERR: begin
                if (tx_fire) begin
                    op_cnt_d = op_cnt_q + 8'd1;
                    state_d  = S_IDLE;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= OP_ADD;
            op_cnt_q   <= 8'h00;
            div0_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            fun_q      <= fun_d;
            op_cnt_q   <= op_cnt_d;
            div0_err_q <= div0_err_d;
        end
    end

    alu_result_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ERR_CODE   (ERR_CODE)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .capture  (state_q == S_WAIT),
        .res_lo   (Arith_OUT_reg),
        .res_hi   (Carry_OUT_reg),
        .send_lo  (state_q == S_SEND_LO),
        .send_hi  (state_q == S_SEND_HI),
        .send_err (state_q == S_ERR),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_fire  (tx_fire)
    );

    assign cmd_ready  = (state_q == S_IDLE);
    assign Arith_En   = (state_q == S_ISSUE);
    assign A_Arith    = a_q;
    assign B_Arith    = b_q;
    assign ALU_FUN_LS = fun_q;
    assign div0_err   = div0_err_q;
    assign op_cnt     = op_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer. A registered arithmetic unit
// stub answers Arith_En; a transaction-level model predicts the byte stream,
// handshake readiness and counters from the command sequence.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] A_Arith;
    logic [7:0] B_Arith;
    logic [1:0] ALU_FUN_LS;
    logic       Arith_En;
    logic [7:0] Arith_OUT_reg;
    logic [7:0] Carry_OUT_reg;
    logic       Arith_Flag_reg;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       div0_err;
    logic [7:0] op_cnt;

    alu_cmd_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .A_Arith        (A_Arith),
        .B_Arith        (B_Arith),
        .ALU_FUN_LS     (ALU_FUN_LS),
        .Arith_En       (Arith_En),
        .Arith_OUT_reg  (Arith_OUT_reg),
        .Carry_OUT_reg  (Carry_OUT_reg),
        .Arith_Flag_reg (Arith_Flag_reg),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .div0_err       (div0_err),
        .op_cnt         (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- arithmetic unit stub (registered, no reset) ----------
    function automatic logic [15:0] alu_unit(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] a16, b16;
        a16 = {8'h00, a};
        b16 = {8'h00, b};
        case (f)
            2'b00:   return a16 + b16;
            2'b01:   return a16 - b16;
            2'b10:   return a16 * b16;
            default: return (b == 8'h00) ? 16'hDEAD : a16 / b16;
        endcase
    endfunction

    always @(posedge clk) begin
        if (Arith_En) {Carry_OUT_reg, Arith_OUT_reg} <= alu_unit(ALU_FUN_LS, A_Arith, B_Arith);
        Arith_Flag_reg <= Arith_En;
    end

    // ---------------- reference model ---------------------------------------
    function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        case (op)
            2'b00:   r = ai + bi;
            2'b01:   r = ai - bi;   // two's-complement wrap via truncation
            2'b10:   r = ai * bi;
            default: r = ai / bi;
        endcase
        return r[15:0];
    endfunction

    bit         m_busy = 1'b0;      // a command is in flight
    int         m_wait = 0;         // cycles before the first byte is offered
    bit         m_en_exp = 1'b0;
    bit         m_div0_exp = 1'b0;
    logic [7:0] m_q[$];             // bytes still to be sent
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_a = 8'h00, m_b = 8'h00;
    int         m_cnt = 0;          // expected op_cnt (mod 256 on compare)
    int         m_acc = 0, m_done = 0, m_pushed = 0;
    logic [7:0] log_q[$];           // bytes actually transferred
    int         en_cycles = 0, div0_cycles = 0, dut_xfers = 0;
    bit         busy_now, exp_valid;
    logic [15:0] m_res;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            m_busy     = 1'b0;
            m_wait     = 0;
            m_en_exp   = 1'b0;
            m_div0_exp = 1'b0;
            m_q.delete();
            m_cnt      = 0;
        end else begin
            busy_now  = m_busy;
            exp_valid = m_busy && (m_wait == 0);
            check("cmd_ready", cmd_ready, !m_busy);
            check("arith_en", Arith_En, m_en_exp);
            check("div0_err", div0_err, m_div0_exp);
            check("tx_valid", tx_valid, exp_valid);
            check("op_cnt", op_cnt, m_cnt[7:0]);
            if (exp_valid) check("tx_data", tx_data, m_q[0]);
            if (m_en_exp) begin
                check("a_arith", A_Arith, m_a);
                check("b_arith", B_Arith, m_b);
                check("alu_fun", ALU_FUN_LS, m_op);
            end
            if (Arith_En) en_cycles++;
            if (div0_err) div0_cycles++;
            if (tx_valid && tx_ready) dut_xfers++;

            // Advance the model across the coming edge.
            if (exp_valid && tx_ready) begin
                void'(m_q.pop_front());
                log_q.push_back(tx_data);
                if (m_q.size() == 0) begin
                    m_busy = 1'b0;
                    m_cnt++;
                    m_done++;
                end
            end else if (m_busy && m_wait > 0) begin
                m_wait--;
            end
            m_en_exp   = 1'b0;
            m_div0_exp = 1'b0;
            if (!busy_now && cmd_valid) begin
                m_acc++;
                m_op   = cmd_op;
                m_a    = cmd_a;
                m_b    = cmd_b;
                m_busy = 1'b1;
                if (cmd_op == 2'b11 && cmd_b == 8'h00) begin
                    m_q.push_back(8'hEE);
                    m_pushed++;
                    m_wait     = 0;
                    m_div0_exp = 1'b1;
                end else begin
                    m_res = ref_result(cmd_op, cmd_a, cmd_b);
                    m_q.push_back(m_res[7:0]);
                    m_q.push_back(m_res[15:8]);
                    m_pushed += 2;
                    m_wait   = 2;
                    m_en_exp = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (m_busy && k < 300) begin
            step(1);
            k++;
        end
        check(name, m_busy, 1'b0);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int acc0, k;
        wait_idle("idle_before_cmd");
        acc0      = m_acc;
        k         = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        while (m_acc == acc0 && k < 20) begin
            step(1);
            k++;
        end
        cmd_valid = 1'b0;
        check("cmd_accept", m_acc - acc0, 1);
    endtask

    task automatic wait_send_lo(input string name);
        int k = 0;
        while (!(m_busy && m_wait == 0) && k < 20) begin
            step(1);
            k++;
        end
        check(name, tx_valid, 1'b1);
    endtask

    // ---------------- test sequence ------------------------------------------
    initial begin
        int e0, d0, acc0, x0, p0, k;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        tx_ready  = 1'b1;
        step(3);

        // Reset state.
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_arith_en", Arith_En, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_div0_err", div0_err, 1'b0);
        check("rst_op_cnt", op_cnt, 8'h00);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_a_arith", A_Arith, 8'h00);
        check("rst_b_arith", B_Arith, 8'h00);
        check("rst_alu_fun", ALU_FUN_LS, 2'b00);
        rst = 1'b1;
        step(2);

        // Add 0xFF + 0x01 -> 0x0100.
        log_q.delete();
        e0 = en_cycles;
        run_cmd(2'b00, 8'hFF, 8'h01);
        wait_idle("add_done");
        check("add_nbytes", log_q.size(), 2);
        check("add_lo", log_q[0], 8'h00);
        check("add_hi", log_q[1], 8'h01);
        check("add_en_cycles", en_cycles - e0, 1);
        check("add_op_cnt", op_cnt, 8'h01);

        // Mul 0x10 * 0x10 -> 0x0100.
        log_q.delete();
        run_cmd(2'b10, 8'h10, 8'h10);
        wait_idle("mul_done");
        check("mul_lo", log_q[0], 8'h00);
        check("mul_hi", log_q[1], 8'h01);

        // Sub 0x05 - 0x07 -> 0xFFFE.
        log_q.delete();
        run_cmd(2'b01, 8'h05, 8'h07);
        wait_idle("sub_done");
        check("sub_lo", log_q[0], 8'hFE);
        check("sub_hi", log_q[1], 8'hFF);

        // Div by zero trap.
        log_q.delete();
        e0 = en_cycles;
        d0 = div0_cycles;
        run_cmd(2'b11, 8'h64, 8'h00);
        wait_idle("div0_done");
        check("div0_nbytes", log_q.size(), 1);
        check("div0_byte", log_q[0], 8'hEE);
        check("div0_en_cycles", en_cycles - e0, 0);
        check("div0_pulse_cycles", div0_cycles - d0, 1);
        check("div0_cmd_ready", cmd_ready, 1'b1);
        check("div0_op_cnt", op_cnt, 8'h04);

        // Div 0x64 / 0x07 with a 5-cycle stall in SEND_LO and busy pulses.
        log_q.delete();
        tx_ready = 1'b0;
        acc0     = m_acc;
        run_cmd(2'b11, 8'h64, 8'h07);
        wait_send_lo("div_stall_reach");
        for (int i = 0; i < 5; i++) begin
            check("stall_tx_valid", tx_valid, 1'b1);
            check("stall_tx_data", tx_data, 8'h0E);
            cmd_valid = i[0] ? 1'b0 : 1'b1;
            cmd_op    = 2'b00;
            cmd_a     = 8'h11;
            cmd_b     = 8'h22;
            step(1);
        end
        cmd_valid = 1'b0;
        tx_ready  = 1'b1;
        wait_idle("div_done");
        check("div_nbytes", log_q.size(), 2);
        check("div_lo", log_q[0], 8'h0E);
        check("div_hi", log_q[1], 8'h00);
        check("div_accepts", m_acc - acc0, 1);
        check("div_op_cnt", op_cnt, 8'h05);

        // Reset asserted while in SEND_HI.
        tx_ready = 1'b0;
        run_cmd(2'b00, 8'h12, 8'h34);
        wait_send_lo("rst_test_reach_lo");
        tx_ready = 1'b1;
        step(1);
        tx_ready = 1'b0;
        check("pre_rst_hi_valid", tx_valid, 1'b1);
        check("pre_rst_hi_data", tx_data, 8'h00);
        #2 rst = 1'b0;
        #1;
        check("async_rst_tx_valid", tx_valid, 1'b0);
        check("async_rst_cmd_ready", cmd_ready, 1'b1);
        check("async_rst_op_cnt", op_cnt, 8'h00);
        check("async_rst_tx_data", tx_data, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;
        tx_ready = 1'b1;
        x0 = dut_xfers;
        step(10);
        check("post_rst_no_bytes", dut_xfers - x0, 0);
        check("post_rst_cmd_ready", cmd_ready, 1'b1);

        // 256 back-to-back adds: op_cnt wraps to 0x00, 2 bytes per command.
        acc0      = m_acc;
        d0        = m_done;
        x0        = dut_xfers;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        k         = 0;
        while (m_acc < acc0 + 256 && k < 3000) begin
            cmd_a = 8'($urandom);
            cmd_b = 8'($urandom);
            step(1);
            k++;
        end
        cmd_valid = 1'b0;
        wait_idle("b2b_done");
        check("b2b_commands", m_done - d0, 256);
        check("b2b_bytes", dut_xfers - x0, 512);
        check("b2b_op_cnt_wrap", op_cnt, 8'h00);

        // Randomised traffic with back-pressure and div-by-zero mixed in.
        x0 = dut_xfers;
        p0 = m_pushed;
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_op    = 2'($urandom);
            cmd_a     = 8'($urandom);
            cmd_b     = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            tx_ready  = ($urandom_range(0, 3) != 0);
            step(1);
        end
        cmd_valid = 1'b0;
        tx_ready  = 1'b1;
        wait_idle("rand_done");
        check("rand_bytes", dut_xfers - x0, m_pushed - p0);
        check("rand_queue_empty", m_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command sequencer that owns the arithmetic unit. It accepts one operand/opcode command at a time from the system controller, drives the arithmetic unit's enable, function and operand inputs for exactly one cycle, and captures the registered 2*DATA_WIDTH result. It then streams the result to the UART TX path as two bytes, low byte first. Division by zero is trapped before issue and answered with an error byte.

Parameters:
DATA_WIDTH, 8, operand width; the result is 2*DATA_WIDTH bits.
ERR_CODE, 8'hEE, byte sent instead of a result when a divide by zero is trapped.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div
cmd_a  in  DATA_WIDTH  operand A
cmd_b  in  DATA_WIDTH  operand B
A_Arith  out  DATA_WIDTH  to arithmetic unit
B_Arith  out  DATA_WIDTH  to arithmetic unit
ALU_FUN_LS  out  2  to arithmetic unit
Arith_En  out  1  to arithmetic unit
Arith_OUT_reg  in  DATA_WIDTH  result low half from arithmetic unit
Carry_OUT_reg  in  DATA_WIDTH  result high half from arithmetic unit
Arith_Flag_reg  in  1  result-valid flag from arithmetic unit
tx_data  out  8  byte to UART TX
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts the byte
div0_err  out  1  one-cycle pulse on a trapped divide by zero
op_cnt  out  8  count of completed commands (including error commands), wraps 0xFF->0x00

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - Arith_En=0, tx_valid=0, div0_err=0, op_cnt=0.
  - A_Arith, B_Arith, ALU_FUN_LS, tx_data, and the internal result register all =0.
  - Reset mid-operation abandons the command. No partial byte is re-sent after reset.
- Handshakes:
  - A command is accepted on a clk edge where cmd_valid && cmd_ready. The op and operands are latched into the A_Arith/B_Arith/ALU_FUN_LS registers.
  - cmd_valid while busy is ignored. There is no queueing.
  - A tx byte transfers on an edge where tx_valid && tx_ready.
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
- FSM states: IDLE, ISSUE, WAIT, SEND_LO, SEND_HI, ERR.
  - IDLE -> ISSUE on accept when !(cmd_op==2'b11 && cmd_b==0).
  - IDLE -> ERR on accept when cmd_op==2'b11 && cmd_b==0. div0_err pulses in the first ERR cycle. Arith_En is never asserted for that command.
  - ISSUE: Arith_En=1 for exactly this one cycle. The arithmetic unit registers its result at the end of ISSUE. Next state is WAIT.
  - WAIT: Arith_Flag_reg is 1 this cycle. Capture result = {Carry_OUT_reg, Arith_OUT_reg}. Next state is SEND_LO.
  - SEND_LO: tx_valid=1, tx_data=result[7:0]. Moves to SEND_HI on transfer.
  - SEND_HI: tx_valid=1, tx_data=result[15:8]. On transfer: op_cnt++, go to IDLE.
  - ERR: tx_valid=1, tx_data=ERR_CODE. On transfer: op_cnt++, go to IDLE.
- Latency with tx_ready tied high:
  - Accept at edge 0; Arith_En high in cycle 1; capture at the end of cycle 2.
  - Low byte valid in cycle 3, high byte in cycle 4.
  - cmd_ready is high again in cycle 5.
- Arithmetic and width rules:
  - The result is the arithmetic unit's 2*DATA_WIDTH output, unmodified.
  - Sub with A<B yields the 16-bit two's-complement wrap.
  - Div yields the quotient with high byte 0.
  - Transmission is fixed at 2 bytes for DATA_WIDTH=8.
- The arithmetic unit has no reset. The sequencer samples its outputs only in WAIT and never uses Arith_Flag_reg for control.
- Arith_En is 0 in every state except ISSUE.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11;
  - FSM state encoding (localparams, 3-bit);
  - the default ERR_CODE.
- One natural sub-module: alu_result_serializer, which holds the result register plus the SEND_LO/SEND_HI/ERR byte handshake. The top keeps the accept/issue/wait control.

Test Plan:
- Add, A=0xFF, B=0x01, tx_ready=1 -> Arith_En high exactly 1 cycle; bytes 0x00 then 0x01; op_cnt 0->1.
- Mul 0x10*0x10 -> bytes 0x00, 0x01. Sub 0x05-0x07 -> bytes 0xFE, 0xFF.
- Div 0x64 by 0x00 -> Arith_En never high; div0_err 1-cycle pulse; single byte 0xEE; cmd_ready back high; op_cnt incremented.
- Div 0x64 by 0x07 with tx_ready low 5 cycles in SEND_LO -> tx_data holds 0x0E with tx_valid=1; cmd_valid pulses during busy are ignored; then 0x0E, 0x00 sent.
- 256 back-to-back adds -> op_cnt wraps to 0x00; each command sends exactly 2 bytes.
- rst asserted in SEND_HI -> tx_valid drops immediately (asynchronous); after release state=IDLE, cmd_ready=1, no further byte emitted.
